// File: rtl/sevseg_pkg.sv
// Shared constants and types for the seven-segment scan reader.
// Patterns are lit-segment codes, abcdefg with bit 6 = a.
package sevseg_pkg;

   // Segments are driven low to light.
   localparam logic LED_ON = 1'b0;

   localparam int unsigned SEG_A = 6;
   localparam int unsigned SEG_B = 5;
   localparam int unsigned SEG_C = 4;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 2;
   localparam int unsigned SEG_F = 1;
   localparam int unsigned SEG_G = 0;

   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1110011;
   localparam logic [6:0] SEG_A_HEX = 7'b1110111;
   localparam logic [6:0] SEG_B_HEX = 7'b0011111;
   localparam logic [6:0] SEG_C_HEX = 7'b1001110;
   localparam logic [6:0] SEG_D_HEX = 7'b0111101;
   localparam logic [6:0] SEG_E_HEX = 7'b1001111;
   localparam logic [6:0] SEG_F_HEX = 7'b1000111;

   typedef enum logic [1:0] {
      ST_WAIT    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2
   } state_e;

endpackage

// File: rtl/sevseg_pattern_decoder.sv
// Combinational decode of an active-low segment bus to a hex nibble.
// Anything that is not an exact hex glyph yields nibble 0 with err set.
import sevseg_pkg::*;

module sevseg_pattern_decoder (
   input  logic [6:0] seg_n,
   output logic [3:0] nibble,
   output logic       err
);

   logic [6:0] lit;

   always_comb begin
      lit        = '0;
      lit[SEG_A] = (seg_n[SEG_A] == LED_ON);
      lit[SEG_B] = (seg_n[SEG_B] == LED_ON);
      lit[SEG_C] = (seg_n[SEG_C] == LED_ON);
      lit[SEG_D] = (seg_n[SEG_D] == LED_ON);
      lit[SEG_E] = (seg_n[SEG_E] == LED_ON);
      lit[SEG_F] = (seg_n[SEG_F] == LED_ON);
      lit[SEG_G] = (seg_n[SEG_G] == LED_ON);
   end

   always_comb begin
      nibble = 4'h0;
      err    = 1'b0;
      case (lit)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A_HEX: nibble = 4'hA;
         SEG_B_HEX: nibble = 4'hB;
         SEG_C_HEX: nibble = 4'hC;
         SEG_D_HEX: nibble = 4'hD;
         SEG_E_HEX: nibble = 4'hE;
         SEG_F_HEX: nibble = 4'hF;
         default: begin
            nibble = 4'h0;
            err    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/sevseg_scan_reader.sv
// Reads back a multiplexed active-low seven-segment bus: settles on each anode,
// captures the decoded digit, and publishes a frame after repeated identical scans.
import sevseg_pkg::*;

module sevseg_scan_reader #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned STABLE_SCANS   = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_n,
   input  logic [DIGITS-1:0]     an_n,
   output logic [4*DIGITS-1:0]   value,
   output logic [DIGITS-1:0]     digit_err,
   output logic                  valid,
   output logic                  locked
);

   localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned MATCH_W = (STABLE_SCANS > 1) ? $clog2(STABLE_SCANS) : 1;
   localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

   // SETTLE is entered one edge after the anode is first seen, so it ends one count early.
   localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
   localparam logic [MATCH_W-1:0] MATCH_MAX   = MATCH_W'(STABLE_SCANS - 1);
   localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

   state_e                state_q, state_d;
   logic [DIGITS-1:0]     an_lat_q, an_lat_d;
   logic [IDX_W-1:0]      slot_q, slot_d;
   logic                  hold_q, hold_d;
   logic [SET_W-1:0]      settle_cnt_q, settle_cnt_d;
   logic [DIGITS-1:0]     mask_q, mask_d;
   logic [4*DIGITS-1:0]   shadow_nib_q, shadow_nib_d;
   logic [DIGITS-1:0]     shadow_err_q, shadow_err_d;
   logic [4*DIGITS-1:0]   prev_nib_q, prev_nib_d;
   logic [DIGITS-1:0]     prev_err_q, prev_err_d;
   logic [MATCH_W-1:0]    match_cnt_q, match_cnt_d;
   logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
   logic                  need_pub_q, need_pub_d;
   logic [4*DIGITS-1:0]   value_q, value_d;
   logic [DIGITS-1:0]     err_q, err_d;
   logic                  valid_q, valid_d;
   logic                  locked_q, locked_d;

   logic [3:0]            dec_nib;
   logic                  dec_err;
   logic [3:0]            n_low;
   logic                  an_onehot;
   logic [IDX_W-1:0]      an_idx;
   logic                  frame_done;
   logic                  frame_equal;

   sevseg_pattern_decoder u_decoder (
      .seg_n  (seg_n),
      .nibble (dec_nib),
      .err    (dec_err)
   );

   always_comb begin
      n_low  = '0;
      an_idx = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (!an_n[i]) begin
            n_low  = n_low + 4'd1;
            an_idx = IDX_W'(i);
         end
      end
      an_onehot = (n_low == 4'd1);
   end

   assign frame_done  = &mask_q;
   assign frame_equal = (shadow_nib_q == prev_nib_q) && (shadow_err_q == prev_err_q);

   always_comb begin
      state_d      = state_q;
      an_lat_d     = an_lat_q;
      slot_d       = slot_q;
      hold_d       = hold_q;
      settle_cnt_d = settle_cnt_q;
      mask_d       = mask_q;
      shadow_nib_d = shadow_nib_q;
      shadow_err_d = shadow_err_q;
      prev_nib_d   = prev_nib_q;
      prev_err_d   = prev_err_q;
      match_cnt_d  = match_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      need_pub_d   = need_pub_q;
      value_d      = value_q;
      err_d        = err_q;
      valid_d      = 1'b0;
      locked_d     = locked_q;

      case (state_q)
         ST_WAIT: begin
            // After a capture, the same anode must go away before it can be read again.
            if (!(hold_q && (an_n == an_lat_q))) begin
               hold_d = 1'b0;
               if (an_onehot) begin
                  an_lat_d     = an_n;
                  slot_d       = an_idx;
                  settle_cnt_d = '0;
                  state_d      = (SETTLE_CYCLES == 1) ? ST_CAPTURE : ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (!an_onehot) begin
               state_d = ST_WAIT;
            end else if (an_n != an_lat_q) begin
               an_lat_d     = an_n;
               slot_d       = an_idx;
               settle_cnt_d = '0;
            end else if (settle_cnt_q == SETTLE_LAST) begin
               state_d = ST_CAPTURE;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         ST_CAPTURE: begin
            state_d                  = ST_WAIT;
            hold_d                   = 1'b1;
            shadow_nib_d[slot_q*4 +: 4] = dec_nib;
            shadow_err_d[slot_q]     = dec_err;
         end
         default: state_d = ST_WAIT;
      endcase

      if (frame_done) begin
         mask_d    = '0;
         tmo_cnt_d = '0;
         if (frame_equal) begin
            if (match_cnt_q != MATCH_MAX) begin
               match_cnt_d = match_cnt_q + 1'b1;
            end
         end else begin
            match_cnt_d = '0;
            prev_nib_d  = shadow_nib_q;
            prev_err_d  = shadow_err_q;
         end
         if (match_cnt_d == MATCH_MAX) begin
            locked_d = 1'b1;
            if (need_pub_q || (shadow_nib_q != value_q) || (shadow_err_q != err_q)) begin
               value_d    = shadow_nib_q;
               err_d      = shadow_err_q;
               valid_d    = 1'b1;
               need_pub_d = 1'b0;
            end
         end
      end else if (tmo_cnt_q == TMO_LAST) begin
         tmo_cnt_d   = '0;
         locked_d    = 1'b0;
         match_cnt_d = '0;
         mask_d      = '0;
         need_pub_d  = 1'b1;
      end else begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end

      // A capture never coincides with frame completion, so the slot bit is simply ORed in.
      if (state_q == ST_CAPTURE) begin
         mask_d[slot_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_WAIT;
         an_lat_q     <= '1;
         slot_q       <= '0;
         hold_q       <= 1'b0;
         settle_cnt_q <= '0;
         mask_q       <= '0;
         shadow_nib_q <= '0;
         shadow_err_q <= '0;
         prev_nib_q   <= '0;
         prev_err_q   <= '0;
         match_cnt_q  <= '0;
         tmo_cnt_q    <= '0;
         need_pub_q   <= 1'b1;
         value_q      <= '0;
         err_q        <= '0;
         valid_q      <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         an_lat_q     <= an_lat_d;
         slot_q       <= slot_d;
         hold_q       <= hold_d;
         settle_cnt_q <= settle_cnt_d;
         mask_q       <= mask_d;
         shadow_nib_q <= shadow_nib_d;
         shadow_err_q <= shadow_err_d;
         prev_nib_q   <= prev_nib_d;
         prev_err_q   <= prev_err_d;
         match_cnt_q  <= match_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         need_pub_q   <= need_pub_d;
         value_q      <= value_d;
         err_q        <= err_d;
         valid_q      <= valid_d;
         locked_q     <= locked_d;
      end
   end

   assign value     = value_q;
   assign digit_err = err_q;
   assign valid     = valid_q;
   assign locked    = locked_q;

endmodule

// File: tb/tb_sevseg_scan_reader.sv
// Directed bench for sevseg_scan_reader: scans known frames on the display bus
// and checks published value, error flags, valid pulses and lock behaviour.
module tb_sevseg_scan_reader;

   localparam int unsigned TMO = 300;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic [15:0] value;
   logic [3:0]  digit_err;
   logic        valid;
   logic        locked;

   int n_checks    = 0;
   int n_pass      = 0;
   int pulses      = 0;
   int dbl_pulses  = 0;
   logic valid_prev = 1'b0;

   always #5 clk = ~clk;

   sevseg_scan_reader #(
      .DIGITS         (4),
      .SETTLE_CYCLES  (4),
      .STABLE_SCANS   (3),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_n     (seg_n),
      .an_n      (an_n),
      .value     (value),
      .digit_err (digit_err),
      .valid     (valid),
      .locked    (locked)
   );

   always @(posedge clk) begin
      #2;
      if (valid) begin
         pulses = pulses + 1;
         if (valid_prev) dbl_pulses = dbl_pulses + 1;
      end
      valid_prev = valid;
   end

   function automatic logic [6:0] lit_of(input logic [3:0] d);
      case (d)
         4'h0: return 7'b1111110;
         4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;
         4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;
         4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;
         4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1110011;
         4'hA: return 7'b1110111;
         4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;
         4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;
         default: return 7'b1000111;
      endcase
   endfunction

   task automatic drive_slot(input int s, input logic [6:0] lit, input int hold);
      an_n  = ~(4'b0001 << s);
      seg_n = ~lit;
      repeat (hold) @(negedge clk);
   endtask

   task automatic idle(input int n);
      an_n  = '1;
      seg_n = '1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_pats(input logic [27:0] pats, input int hold);
      for (int s = 3; s >= 0; s--) drive_slot(s, pats[s*7 +: 7], hold);
   endtask

   task automatic send_value(input logic [15:0] v, input int hold);
      logic [27:0] pats;
      for (int s = 0; s < 4; s++) pats[s*7 +: 7] = lit_of(v[s*4 +: 4]);
      send_pats(pats, hold);
   endtask

   task automatic test_reset();
      n_checks++; if (value !== 16'h0) $display("FAIL reset_value: got %h want %h", value, 16'h0); else n_pass++;
      n_checks++; if (digit_err !== 4'h0) $display("FAIL reset_err: got %b want %b", digit_err, 4'h0); else n_pass++;
      n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
   endtask

   task automatic test_basic();
      int p0;
      p0 = pulses;
      send_value(16'h1A2F, 8);
      send_value(16'h1A2F, 8);
      n_checks++; if (pulses !== p0) $display("FAIL basic_early_pulse: got %0d want %0d", pulses - p0, 0); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL basic_early_locked: got %b want 0", locked); else n_pass++;
      send_value(16'h1A2F, 8);
      n_checks++; if (pulses !== p0 + 1) $display("FAIL basic_pulse: got %0d want %0d", pulses - p0, 1); else n_pass++;
      n_checks++; if (value !== 16'h1A2F) $display("FAIL basic_value: got %h want %h", value, 16'h1A2F); else n_pass++;
      n_checks++; if (digit_err !== 4'h0) $display("FAIL basic_err: got %b want %b", digit_err, 4'h0); else n_pass++;
      n_checks++; if (locked !== 1'b1) $display("FAIL basic_locked: got %b want 1", locked); else n_pass++;
      send_value(16'h1A2F, 8);
      n_checks++; if (pulses !== p0 + 1) $display("FAIL basic_repeat_pulse: got %0d want %0d", pulses - p0, 1); else n_pass++;
   endtask

   task automatic test_change();
      int p0;
      p0 = pulses;
      send_value(16'h172F, 8);
      send_value(16'h172F, 8);
      n_checks++; if (pulses !== p0) $display("FAIL change_early_pulse: got %0d want %0d", pulses - p0, 0); else n_pass++;
      n_checks++; if (value !== 16'h1A2F) $display("FAIL change_early_value: got %h want %h", value, 16'h1A2F); else n_pass++;
      send_value(16'h172F, 8);
      n_checks++; if (pulses !== p0 + 1) $display("FAIL change_pulse: got %0d want %0d", pulses - p0, 1); else n_pass++;
      n_checks++; if (value !== 16'h172F) $display("FAIL change_value: got %h want %h", value, 16'h172F); else n_pass++;
   endtask

   task automatic test_bad_pattern();
      int p0;
      logic [27:0] pats;
      p0 = pulses;
      pats = {lit_of(4'h1), lit_of(4'h7), 7'b1111000, lit_of(4'hF)};
      repeat (3) send_pats(pats, 8);
      n_checks++; if (pulses !== p0 + 1) $display("FAIL bad_pulse: got %0d want %0d", pulses - p0, 1); else n_pass++;
      n_checks++; if (value !== 16'h170F) $display("FAIL bad_value: got %h want %h", value, 16'h170F); else n_pass++;
      n_checks++; if (digit_err !== 4'b0010) $display("FAIL bad_err: got %b want %b", digit_err, 4'b0010); else n_pass++;
   endtask

   task automatic test_short_hold();
      int p0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      p0 = pulses;
      repeat (6) send_value(16'h1A2F, 3);
      idle(10);
      n_checks++; if (pulses !== p0) $display("FAIL short_pulse: got %0d want %0d", pulses - p0, 0); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL short_locked: got %b want 0", locked); else n_pass++;
      n_checks++; if (value !== 16'h0) $display("FAIL short_value: got %h want %h", value, 16'h0); else n_pass++;
   endtask

   task automatic test_glitch();
      int p0;
      p0 = pulses;
      send_value(16'h1A2F, 8);
      drive_slot(3, lit_of(4'h1), 8);
      drive_slot(2, lit_of(4'hA), 8);
      drive_slot(1, lit_of(4'h8), 3);
      an_n  = 4'b1100;
      seg_n = ~lit_of(4'h8);
      repeat (2) @(negedge clk);
      drive_slot(1, lit_of(4'h2), 8);
      drive_slot(0, lit_of(4'hF), 8);
      send_value(16'h1A2F, 8);
      n_checks++; if (pulses !== p0 + 1) $display("FAIL glitch_pulse: got %0d want %0d", pulses - p0, 1); else n_pass++;
      n_checks++; if (value !== 16'h1A2F) $display("FAIL glitch_value: got %h want %h", value, 16'h1A2F); else n_pass++;
      n_checks++; if (digit_err !== 4'h0) $display("FAIL glitch_err: got %b want %b", digit_err, 4'h0); else n_pass++;
      n_checks++; if (locked !== 1'b1) $display("FAIL glitch_locked: got %b want 1", locked); else n_pass++;
   endtask

   task automatic test_timeout();
      int p0;
      p0 = pulses;
      idle(TMO - 20);
      n_checks++; if (locked !== 1'b1) $display("FAIL tmo_early_locked: got %b want 1", locked); else n_pass++;
      idle(40);
      n_checks++; if (locked !== 1'b0) $display("FAIL tmo_locked: got %b want 0", locked); else n_pass++;
      n_checks++; if (value !== 16'h1A2F) $display("FAIL tmo_value_kept: got %h want %h", value, 16'h1A2F); else n_pass++;
      n_checks++; if (pulses !== p0) $display("FAIL tmo_pulse: got %0d want %0d", pulses - p0, 0); else n_pass++;
      repeat (3) send_value(16'h1A2F, 8);
      n_checks++; if (pulses !== p0 + 1) $display("FAIL tmo_relock_pulse: got %0d want %0d", pulses - p0, 1); else n_pass++;
      n_checks++; if (locked !== 1'b1) $display("FAIL tmo_relock: got %b want 1", locked); else n_pass++;
   endtask

   task automatic test_reset_midframe();
      int p0;
      p0 = pulses;
      drive_slot(3, lit_of(4'h4), 8);
      drive_slot(2, lit_of(4'h5), 2);
      #2 rst = 1'b1;
      #1;
      n_checks++; if (value !== 16'h0) $display("FAIL rstmid_value: got %h want %h", value, 16'h0); else n_pass++;
      n_checks++; if (digit_err !== 4'h0) $display("FAIL rstmid_err: got %b want %b", digit_err, 4'h0); else n_pass++;
      n_checks++; if (valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", valid); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL rstmid_locked: got %b want 0", locked); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      drive_slot(2, lit_of(4'h5), 8);
      drive_slot(1, lit_of(4'h6), 8);
      drive_slot(0, lit_of(4'h7), 8);
      idle(20);
      n_checks++; if (pulses !== p0) $display("FAIL rstmid_pulse: got %0d want %0d", pulses - p0, 0); else n_pass++;
      n_checks++; if (value !== 16'h0) $display("FAIL rstmid_after_value: got %h want %h", value, 16'h0); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL rstmid_after_locked: got %b want 0", locked); else n_pass++;
   endtask

   initial begin
      rst   = 1'b1;
      an_n  = '1;
      seg_n = '1;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_basic();
      test_change();
      test_bad_pattern();
      test_short_hold();
      test_glitch();
      test_timeout();
      test_reset_midframe();
      n_checks++; if (dbl_pulses !== 0) $display("FAIL valid_width: got %0d long pulses want %0d", dbl_pulses, 0); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sevseg_scan_reader.md
# sevseg_scan_reader

Recovers hex digits from a multiplexed, active-low seven-segment display bus: an anode select plus a shared segment bus. It is the read-back end of our segment-driving path. It sits beside the display driver, or on pins from an external display, for self-check and logging. For each anode slot it waits for the bus to settle, samples the segments, and decodes the pattern to a nibble. It publishes a multi-digit value only after several identical full scans.

## Interface
- DIGITS, 4: number of multiplexed digits (1..8).
- SETTLE_CYCLES, 4: clocks an anode must stay unchanged before segments are sampled (≥1).
- STABLE_SCANS, 3: consecutive identical complete frames required before publishing (≥1).
- TIMEOUT_CYCLES, 1048576: clocks without a completed frame before lock is dropped.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_n  in  7  segments, active-low; bit 6 = a … bit 0 = g.
- an_n  in  DIGITS  anode selects, active-low; exactly one low = valid slot; bit 0 = least-significant digit.
- value  out  4*DIGITS  published digits; nibble i = digit i.
- digit_err  out  DIGITS  published per-digit invalid-pattern flags.
- valid  out  1  one-cycle pulse when value/digit_err update.
- locked  out  1  high while stable frames keep arriving.

## Operation
- Decode, with lit segments written as abcdefg (1 = lit, i.e. seg_n inverted):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1110011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - Only exact matches are valid. Any other pattern, including all-dark, gives nibble 0 and err=1.
- FSM states: WAIT, SETTLE, CAPTURE.
  - WAIT: stays here while an_n is not one-hot. On a one-hot an_n, latch the slot index, clear settle_cnt, and go to SETTLE.
  - SETTLE: an_n must hold the latched slot. If an_n changes to a different one-hot value, relatch and clear settle_cnt. If it goes non-one-hot, return to WAIT. When settle_cnt reaches SETTLE_CYCLES-1, go to CAPTURE.
  - CAPTURE: a single cycle. Write the decoded nibble and err into the shadow slot and set its captured_mask bit; rewriting an already-captured slot overwrites it. Then wait in WAIT-like hold until an_n changes; re-entry requires an_n to differ from the captured slot.
- Frame completion: when captured_mask is all-ones, compare the shadow frame (nibbles + errs) with the previous frame, then clear captured_mask.
  - Equal: match_cnt++, saturating at STABLE_SCANS-1. Otherwise match_cnt=0 and the previous frame is replaced.
  - Publish when match_cnt reaches STABLE_SCANS-1 (immediately if STABLE_SCANS=1).
  - On publish: set locked=1. Load value/digit_err and pulse valid only if the frame differs from the current outputs, or on the first publish after reset or timeout.
- Timeout: a counter is cleared on each frame completion. On reaching TIMEOUT_CYCLES: locked=0, match_cnt=0, captured_mask=0. value and digit_err are retained and valid is not pulsed.

## Timing
- Reset values: value=0, digit_err=0, valid=0, locked=0, FSM=WAIT, captured_mask=0, match_cnt=0, timeout counter=0.
- Reset is asynchronous and may arrive mid-frame; the partial frame is discarded.
- Sample point: an_n is first seen one-hot at edge 0. seg_n is sampled at edge SETTLE_CYCLES (the CAPTURE cycle).
- Publish latency: value/digit_err/valid register one clock after the CAPTURE edge that completes the publishing frame.
- valid is high for exactly one cycle, with value and digit_err already updated in that cycle.
- If timeout and frame completion occur in the same cycle, frame completion wins and the counter clears.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package sevseg_pkg holds:
  - the 16 lit-pattern constants SEG_0..SEG_F (7-bit abcdefg);
  - the LED_ON polarity constant;
  - the segment bit-index constants;
  - the FSM state enum.
- Sub-module sevseg_pattern_decoder: combinational, 7-bit active-low segments in, nibble + err out. It is instantiated once, on seg_n.
- The top level holds the FSM, settle/timeout counters, shadow and previous frames, match counter, and output registers.

## Test plan
Defaults for all scenarios: DIGITS=4, SETTLE_CYCLES=4, STABLE_SCANS=3.
- Scan digits 3..0 showing "1A2F", 8 clocks per slot, 3 frames → one valid pulse; value=16'h1A2F, digit_err=0, locked=1. A 4th identical frame produces no pulse.
- Stable "1A2F", then digit 2 changes to "7" → after 3 frames of "172F", one pulse with value=16'h172F.
- Digit 1 pattern 1111000 → value nibble 1 = 0, digit_err=4'b0010, valid pulses.
- Anode held only 3 clocks per slot → no capture, no valid; locked stays 0.
- Anode glitch: two anodes low mid-settle → that slot is re-settled from scratch; the published value is unaffected.
- Locked, then an_n=all-high for TIMEOUT_CYCLES → locked=0 and value retained. Three clean frames → valid pulses again, locked=1.
- Assert rst mid-frame → all outputs 0 on the same edge. A partial frame before rst never publishes.
